mod_stream_sched: RTL and testbench
===================================

Name: mod_stream_sched

Overview:
- Shares one serial remainder-update datapath, r' = (2r + bit) mod DIVISOR, between NUM_CH requesters.
- Each requester streams bits MSB-first with a valid/ready handshake.
- Round-robin arbitration grants at most one bit per cycle.
- The block holds a per-channel remainder context and reports, per channel, whether the value accumulated so far is divisible by DIVISOR.

Parameters:
- NUM_CH, 4: number of requester channels, >= 2.
- DIVISOR, 5: modulus, >= 2.
- RW, $clog2(DIVISOR): remainder width. Localparam, not overridable.
- CH_W, $clog2(NUM_CH): channel index width. Localparam.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- req_valid  input  NUM_CH  per-channel bit valid
- req_bit  input  NUM_CH  per-channel data bit
- req_ready  output  NUM_CH  one-hot grant. Combinational; transfer occurs when valid & ready.
- ch_clear  input  NUM_CH  per-channel context clear
- grant_valid  output  1  a transfer occurs this cycle. Combinational.
- grant_id  output  CH_W  index of the granted channel. 0 when grant_valid = 0.
- div_flag  output  NUM_CH  registered: channel value divisible by DIVISOR

Behaviour:
- Reset (resetn = 0 at posedge):
  - rem[*] = 0, started[*] = 0, rr_ptr = 0, div_flag = 0.
  - req_ready and grant_valid are forced to 0 combinationally while resetn = 0.
- Eligibility: channel i is eligible when req_valid[i] & ~ch_clear[i].
- Arbitration:
  - The grant goes to the first eligible channel scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH.
  - No eligible channel: req_ready = 0, grant_valid = 0, rr_ptr unchanged.
- On a transfer to channel g:
  - t = 2*rem[g] + req_bit[g], computed at RW+1 bits.
  - rem[g] <= (t >= DIVISOR) ? t - DIVISOR : t. A single conditional subtract suffices because t < 2*DIVISOR.
  - started[g] <= 1.
  - rr_ptr <= (g == NUM_CH-1) ? 0 : g+1.
- Non-granted channels hold rem and started.
- div_flag[i] <= started_next[i] & (rem_next[i] == 0).
  - The flag is valid on the cycle after the accepting edge, i.e. one-cycle latency from the transfer.
- Empty stream is not "divisible":
  - After reset or clear, div_flag = 0 until at least one bit has been accepted.
  - A zero accepted in reset is never counted.
- ch_clear[i]:
  - At the next edge, rem[i] <= 0, started[i] <= 0, div_flag[i] <= 0.
  - Channel i is masked from arbitration that cycle, so clear beats a simultaneous bit, which is not accepted.
- Simultaneous requests: exactly one is granted; the others hold valid/bit stable until granted (standard valid/ready rules).
- Fairness: under continuous requests from k channels, each channel is granted once every k cycles.
- Reset mid-stream: all contexts are discarded. rr_ptr returns to 0, and no transfer occurs during the reset cycle.

Optional Feature:
- Macro: MOD_STREAM_SCHED_LEN_CNT_EN.
- Defined:
  - Adds output bit_len [NUM_CH*16], a per-channel saturating count of accepted bits.
  - Each count resets to 0 on resetn or ch_clear[i] and increments on each transfer to channel i.
  - Saturates at 16'hFFFF.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults; ch0 streams 1,0,1,0 (values 1,2,5,10) -> div_flag[0] = 0,0,1,1, each one cycle after its accept; other flags stay 0.
- All four channels continuously valid -> grant_id sequence 0,1,2,3,0,1,...; each req_ready is high 1 cycle in 4.
- After reset, ch1 sends a single 0 -> div_flag[1] stays 0 during and directly after reset, then is 1 one cycle after the accept.
- rr_ptr = 2; req_valid[2] and req_valid[3] high with ch_clear[2] high -> grant_id = 3; then rem[2] = 0 and div_flag[2] = 0.
- ch3 streams 1,1,1,1 (values 1,3,7,15) -> div_flag[3] = 0,0,0,1. With MOD_STREAM_SCHED_LEN_CNT_EN defined, bit_len[ch3] = 4.
- ch1 reaches value 3, then resetn is pulsed for 1 cycle -> all div_flag = 0; the next request from ch0 is granted first (rr_ptr = 0).

Source files
------------

// File: rtl/mod_stream_sched.sv
// rtl/mod_stream_sched.sv - round-robin shared serial mod-DIVISOR remainder engine for NUM_CH bit streams
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   req_valid/req_bit per-channel MSB-first bit stream (valid/ready handshake)
//   req_ready        one-hot combinational grant; a bit moves when valid & ready
//   ch_clear         per-channel context clear, masks that channel from arbitration
//   grant_valid      a transfer happens this cycle (combinational)
//   grant_id         granted channel index, 0 when grant_valid = 0
//   div_flag         registered, accumulated value of the channel is divisible by DIVISOR
//   bit_len          (MOD_STREAM_SCHED_LEN_CNT_EN only) per-channel 16-bit saturating accepted-bit count
//
// Optional build macro: MOD_STREAM_SCHED_LEN_CNT_EN

module mod_stream_sched #(
    parameter int NUM_CH  = 4,
    parameter int DIVISOR = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_CH-1:0]      req_valid,
    input  logic [NUM_CH-1:0]      req_bit,
    output logic [NUM_CH-1:0]      req_ready,
    input  logic [NUM_CH-1:0]      ch_clear,
    output logic                   grant_valid,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic [NUM_CH-1:0]      div_flag
`ifdef MOD_STREAM_SCHED_LEN_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]   bit_len
`endif
);

    localparam int RW   = $clog2(DIVISOR);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int TW   = RW + 1;
    localparam logic [TW-1:0]   DIV_T   = TW'(DIVISOR);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0][RW-1:0] rem_q, rem_d;
    logic [NUM_CH-1:0]         started_q, started_d;
    logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]         div_flag_q, div_flag_d;

    logic [NUM_CH-1:0] eligible;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic [TW-1:0]     t;
    logic [TW-1:0]     t_sub;

    // A channel being cleared is never eligible, so clear wins over a bit.
    assign eligible = req_valid & ~ch_clear;

    // Scan starting at rr_ptr, wrapping; first eligible channel wins.
    always_comb begin : arb_comb
        logic [CH_W-1:0] scan;
        scan        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!grant_found && eligible[scan]) begin
                grant_found = 1'b1;
                grant_idx   = scan;
            end
        end
    end

    // Handshake outputs are suppressed during reset so nothing is accepted.
    always_comb begin
        grant_valid = resetn & grant_found;
        req_ready   = '0;
        grant_id    = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
            grant_id             = grant_idx;
        end
    end

    // t < 2*DIVISOR, so one conditional subtract gives the remainder.
    always_comb begin
        t     = {rem_q[grant_idx], req_bit[grant_idx]};
        t_sub = t - DIV_T;
    end

    always_comb begin
        rem_d      = rem_q;
        started_d  = started_q;
        rr_ptr_d   = rr_ptr_q;
        div_flag_d = '0;
        if (grant_valid) begin
            rem_d[grant_idx]     = (t >= DIV_T) ? t_sub[RW-1:0] : t[RW-1:0];
            started_d[grant_idx] = 1'b1;
            rr_ptr_d             = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_clear[i]) begin
                rem_d[i]     = '0;
                started_d[i] = 1'b0;
            end
            // An empty stream is not reported as divisible.
            div_flag_d[i] = started_d[i] & (rem_d[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q      <= '0;
            started_q  <= '0;
            rr_ptr_q   <= '0;
            div_flag_q <= '0;
        end else begin
            rem_q      <= rem_d;
            started_q  <= started_d;
            rr_ptr_q   <= rr_ptr_d;
            div_flag_q <= div_flag_d;
        end
    end

    assign div_flag = div_flag_q;

`ifdef MOD_STREAM_SCHED_LEN_CNT_EN
    logic [NUM_CH-1:0][15:0] len_q, len_d;

    always_comb begin
        len_d = len_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_clear[i]) begin
                len_d[i] = '0;
            end else if (req_ready[i] && len_q[i] != 16'hFFFF) begin
                len_d[i] = len_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    assign bit_len = len_q;
`endif

endmodule

// File: tb/tb_mod_stream_sched.sv
// tb/tb_mod_stream_sched.sv - directed self-checking bench for mod_stream_sched (NUM_CH=4, DIVISOR=5)

module tb_mod_stream_sched;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] req_valid;
    logic [3:0] req_bit;
    logic [3:0] req_ready;
    logic [3:0] ch_clear;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] div_flag;
`ifdef MOD_STREAM_SCHED_LEN_CNT_EN
    logic [63:0] bit_len;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mod_stream_sched #(.NUM_CH(4), .DIVISOR(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_bit     (req_bit),
        .req_ready   (req_ready),
        .ch_clear    (ch_clear),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .div_flag    (div_flag)
`ifdef MOD_STREAM_SCHED_LEN_CNT_EN
        ,
        .bit_len     (bit_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive, check combinational grant, then check flags after the edge.
    task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] e_rdy, input logic e_gv, input logic [1:0] e_gid,
                       input logic [3:0] e_flag);
        req_valid = v;
        req_bit   = b;
        ch_clear  = c;
        #1;
        check({tag, "/req_ready"},   32'(req_ready),   32'(e_rdy));
        check({tag, "/grant_valid"}, 32'(grant_valid), 32'(e_gv));
        check({tag, "/grant_id"},    32'(grant_id),    32'(e_gid));
        @(posedge clk);
        #1;
        check({tag, "/div_flag"},    32'(div_flag),    32'(e_flag));
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        ch_clear  = '0;
        @(posedge clk);
        #1;

        // Reset: handshake forced low even with all channels requesting.
        cyc("rst0", 4'hF, 4'hF, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0000);
        cyc("rst1", 4'hF, 4'h0, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0000);
        resetn = 1'b1;

        // ch0 streams 1,0,1,0 -> values 1,2,5,10.
        cyc("a1", 4'b0001, 4'b0001, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b0000);
        cyc("a2", 4'b0001, 4'b0000, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b0000);
        cyc("a3", 4'b0001, 4'b0001, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b0001);
        cyc("a4", 4'b0001, 4'b0000, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b0001);

        // Reset, then all four channels continuously valid with zero bits.
        resetn = 1'b0;
        cyc("rstb", 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0000);
        resetn = 1'b1;
        cyc("b0", 4'hF, 4'h0, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b0001);
        cyc("b1", 4'hF, 4'h0, 4'h0, 4'b0010, 1'b1, 2'd1, 4'b0011);
        cyc("b2", 4'hF, 4'h0, 4'h0, 4'b0100, 1'b1, 2'd2, 4'b0111);
        cyc("b3", 4'hF, 4'h0, 4'h0, 4'b1000, 1'b1, 2'd3, 4'b1111);
        cyc("b4", 4'hF, 4'h0, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b1111);
        cyc("b5", 4'hF, 4'h0, 4'h0, 4'b0010, 1'b1, 2'd1, 4'b1111);

        // Zero offered during reset is not counted; single accepted zero is divisible.
        resetn = 1'b0;
        cyc("c_rst", 4'b0010, 4'h0, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0000);
        resetn = 1'b1;
        cyc("c_idle", 4'b0000, 4'h0, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0000);
        cyc("c_acc",  4'b0010, 4'h0, 4'h0, 4'b0010, 1'b1, 2'd1, 4'b0010);

        // rr_ptr = 2: clear on ch2 beats its request, ch3 granted.
        cyc("d1", 4'b1100, 4'b0000, 4'b0100, 4'b1000, 1'b1, 2'd3, 4'b1010);
        cyc("d2", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 4'b1010);
        cyc("d3", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 4'b1010);
        cyc("d4", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 4'b1110);

        // ch3 cleared, then streams 1,1,1,1 -> values 1,3,7,15.
        cyc("e_clr", 4'b0000, 4'h0, 4'b1000, 4'b0000, 1'b0, 2'd0, 4'b0110);
        cyc("e1", 4'b1000, 4'b1000, 4'h0, 4'b1000, 1'b1, 2'd3, 4'b0110);
        cyc("e2", 4'b1000, 4'b1000, 4'h0, 4'b1000, 1'b1, 2'd3, 4'b0110);
        cyc("e3", 4'b1000, 4'b1000, 4'h0, 4'b1000, 1'b1, 2'd3, 4'b0110);
        cyc("e4", 4'b1000, 4'b1000, 4'h0, 4'b1000, 1'b1, 2'd3, 4'b1110);
`ifdef MOD_STREAM_SCHED_LEN_CNT_EN
        check("len_ch3", 32'(bit_len[63:48]), 32'd4);
        check("len_ch2", 32'(bit_len[47:32]), 32'd1);
        check("len_ch1", 32'(bit_len[31:16]), 32'd1);
`endif

        // ch1 builds value 3 (rr_ptr ends at 2), then reset mid-stream.
        cyc("f1", 4'b0010, 4'b0010, 4'h0, 4'b0010, 1'b1, 2'd1, 4'b1100);
        cyc("f2", 4'b0010, 4'b0010, 4'h0, 4'b0010, 1'b1, 2'd1, 4'b1100);
        resetn = 1'b0;
        cyc("f_rst", 4'b0000, 4'h0, 4'h0, 4'b0000, 1'b0, 2'd0, 4'b0000);
        resetn = 1'b1;
        cyc("f3", 4'b0101, 4'b0000, 4'h0, 4'b0001, 1'b1, 2'd0, 4'b0001);
        cyc("f4", 4'b0100, 4'b0000, 4'h0, 4'b0100, 1'b1, 2'd2, 4'b0101);
`ifdef MOD_STREAM_SCHED_LEN_CNT_EN
        check("len_ch1_rst", 32'(bit_len[31:16]), 32'd0);
`endif

        req_valid = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
